// File: rtl/ripple_carry_adder_16_if.sv
// Operand/result bundle for the ripple-carry adder: inputs, combinational and registered results.
interface ripple_carry_adder_16_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // Driver of the operands; consumer of all results.
    modport master (
        output a, b, cin,
        input  sum, cout, ovf, sum_q, cout_q, ovf_q
    );

    // The adder itself.
    modport slave (
        input  a, b, cin,
        output sum, cout, ovf, sum_q, cout_q, ovf_q
    );
endinterface

// File: rtl/ripple_carry_adder_16.sv
// Ripple-carry adder built from a chain of 1-bit full-adder cells, with a
// combinational result and a registered copy carrying a signed-overflow flag.

// Single full-adder cell of the carry chain.
module ripple_carry_adder_16_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    // Propagate term shared by sum and carry.
    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module ripple_carry_adder_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ripple_carry_adder_16_if.slave  bus
);
    // Carry chain: carry[0] is the carry-in, carry[WIDTH] the carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             ovf_d;
    logic             ovf_q;

    assign carry[0] = bus.cin;

    // One cell per bit; carry ripples strictly from bit 0 upward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ripple_carry_adder_16_fa u_fa (
            .a_i (bus.a[i]),
            .b_i (bus.b[i]),
            .c_i (carry[i]),
            .s_o (sum_c[i]),
            .c_o (carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign cout_c = carry[WIDTH];
    assign ovf_c  = carry[WIDTH] ^ carry[WIDTH-1];

    assign bus.sum  = sum_c;
    assign bus.cout = cout_c;
    assign bus.ovf  = ovf_c;

    // Next register values: capture the live result every cycle, no enable.
    always_comb begin
        sum_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        sum_d  = sum_c;
        cout_d = cout_c;
        ovf_d  = ovf_c;
    end

    // Result registers, cleared immediately on reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.sum_q  = sum_q;
    assign bus.cout_q = cout_q;
    assign bus.ovf_q  = ovf_q;
endmodule

// File: tb/tb_ripple_carry_adder_16.sv
// Scoreboard bench for ripple_carry_adder_16: directed edge cases, random
// vectors, and asynchronous reset behaviour.
module tb_ripple_carry_adder_16;
    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic vld;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    ripple_carry_adder_16_if #(.WIDTH(W)) bus ();

    ripple_carry_adder_16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed range for ovf.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        int unsigned u;
        int s;
        u = int'(a) + int'(b) + int'(cin);
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        e.sum  = W'(u);
        e.cout = (u >= (1 << W));
        e.ovf  = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        return e;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        exp_q.push_back(model(a, b, cin));
        vld = 1'b1;
    endtask

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        drive(a, b, cin);
    endtask

    // Monitor: for each issued vector, check live and registered results after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (vld && rst_n) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum",    32'(bus.sum),    32'(e.sum));
                    chk("cout",   32'(bus.cout),   32'(e.cout));
                    chk("ovf",    32'(bus.ovf),    32'(e.ovf));
                    chk("sum_q",  32'(bus.sum_q),  32'(e.sum));
                    chk("cout_q", 32'(bus.cout_q), 32'(e.cout));
                    chk("ovf_q",  32'(bus.ovf_q),  32'(e.ovf));
                end
            end
        end
    end

    logic [W-1:0] da [8];
    logic [W-1:0] db [8];
    logic         dc [8];

    initial begin
        da = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h8000};
        db = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h1111, 16'hFFFF};
        dc = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0};

        // Reset state, with live outputs still valid while in reset.
        rst_n   = 1'b0;
        vld     = 1'b0;
        bus.a   = 16'h7FFF;
        bus.b   = 16'h0001;
        bus.cin = 1'b0;
        #3;
        chk("rst_sum_q",  32'(bus.sum_q),  32'h0);
        chk("rst_cout_q", 32'(bus.cout_q), 32'h0);
        chk("rst_ovf_q",  32'(bus.ovf_q),  32'h0);
        chk("rst_live_sum", 32'(bus.sum), 32'h8000);
        chk("rst_live_ovf", 32'(bus.ovf), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed edge cases.
        for (int i = 0; i < 8; i++) apply(da[i], db[i], dc[i]);

        // Random vectors.
        for (int i = 0; i < 1000; i++) apply(W'($urandom), W'($urandom), 1'($urandom));

        // Register latency with a known constant.
        apply(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        chk("reg_1234_1111", 32'(bus.sum_q), 32'h2345);

        // Mid-cycle asynchronous reset discards the pending result.
        @(negedge clk);
        vld     = 1'b0;
        bus.a   = 16'hAAAA;
        bus.b   = 16'h5555;
        bus.cin = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sum_q",  32'(bus.sum_q),  32'h0);
        chk("async_cout_q", 32'(bus.cout_q), 32'h0);
        chk("async_ovf_q",  32'(bus.ovf_q),  32'h0);
        @(posedge clk);
        #1;
        chk("held_sum_q",  32'(bus.sum_q),  32'h0);
        chk("held_cout_q", 32'(bus.cout_q), 32'h0);

        // Release; capture resumes at the next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0F0F, 16'h0101, 1'b1);
        @(posedge clk);
        #1;
        chk("resume_sum_q", 32'(bus.sum_q), 32'h1011);
        @(negedge clk);
        vld = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
